// File: rtl/pulse_timing_pkg.sv
// Shared types for the trigger->response timing checker: check modes, error codes, channel FSM.
package pulse_timing_pkg;

    localparam int unsigned MODE_W = 2;
    localparam int unsigned CODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        ModeExact  = 2'd0,
        ModeWindow = 2'd1,
        ModeForbid = 2'd2,
        ModeOff    = 2'd3
    } mode_t;

    typedef enum logic [CODE_W-1:0] {
        ErrNone    = 2'd0,
        ErrEarly   = 2'd1,
        ErrLate    = 2'd2,
        ErrOverlap = 2'd3
    } err_code_t;

    // A forbidden-window hit shares its code with EARLY.
    localparam err_code_t ErrHit = ErrEarly;

    typedef logic ch_state_t;
    localparam ch_state_t StIdle = 1'b0;
    localparam ch_state_t StWait = 1'b1;

    typedef struct packed {
        logic      done;
        logic      fail;
        err_code_t code;
    } verdict_t;

endpackage

// File: rtl/pulse_timing_channel.sv
// One checker channel: edge detection, elapsed counter, IDLE/WAIT FSM and error status.
module pulse_timing_channel
    import pulse_timing_pkg::*;
#(
    parameter int unsigned DLY_W    = 8,
    parameter int unsigned ERRCNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                first_i,
    input  logic                second_i,
    input  logic [MODE_W-1:0]   mode_i,
    input  logic [DLY_W-1:0]    dly_min_i,
    input  logic [DLY_W-1:0]    dly_max_i,
    input  logic                disable_i,
    input  logic                clr_i,
    output logic                pass_o,
    output logic                err_o,
    output logic [CODE_W-1:0]   err_code_o,
    output logic                err_sticky_o,
    output logic [ERRCNT_W-1:0] err_cnt_o
);

    typedef logic [DLY_W:0] elapsed_t;
    localparam elapsed_t ElapsedMax = '1;
    localparam elapsed_t ElapsedOne = elapsed_t'(1);

    logic                first_q, second_q;
    logic                rise_first, rise_second;
    ch_state_t           state_q, state_d;
    elapsed_t            elapsed_q, elapsed_d;
    mode_t               mode_q, mode_d, mode_in;
    logic [DLY_W-1:0]    min_q, min_d, max_q, max_d;
    verdict_t            verdict;
    logic                pass_d, err_d;
    err_code_t           code_d, code_q;
    logic                pass_q, err_q, sticky_q;
    logic [ERRCNT_W-1:0] cnt_q;

    function automatic verdict_t judge(input mode_t mode, input logic [DLY_W-1:0] dmin,
                                       input logic [DLY_W-1:0] dmax, input elapsed_t el,
                                       input logic sec);
        verdict_t v;
        elapsed_t lo, hi;
        lo     = {1'b0, dmin};
        hi     = {1'b0, dmax};
        v.done = 1'b0;
        v.fail = 1'b0;
        v.code = ErrNone;
        case (mode)
            ModeExact: begin
                if (sec) begin
                    v.done = 1'b1;
                    if (el != lo) begin
                        v.fail = 1'b1;
                        v.code = (el < lo) ? ErrEarly : ErrLate;
                    end
                end else if (el == lo + ElapsedOne) begin
                    v.done = 1'b1;
                    v.fail = 1'b1;
                    v.code = ErrLate;
                end
            end
            ModeWindow: begin
                if (sec) begin
                    v.done = 1'b1;
                    if (el < lo || el > hi) begin
                        v.fail = 1'b1;
                        v.code = (el < lo) ? ErrEarly : ErrLate;
                    end
                end else if (el == hi + ElapsedOne) begin
                    v.done = 1'b1;
                    v.fail = 1'b1;
                    v.code = ErrLate;
                end
            end
            ModeForbid: begin
                if (sec) begin
                    v.done = 1'b1;
                    if (el >= lo && el <= hi) begin
                        v.fail = 1'b1;
                        v.code = ErrHit;
                    end
                end else if (el == hi + ElapsedOne) begin
                    v.done = 1'b1;
                end
            end
            default: ;
        endcase
        return v;
    endfunction

    assign rise_first  = first_i & ~first_q;
    assign rise_second = second_i & ~second_q;
    assign mode_in     = mode_t'(mode_i);

    always_comb begin
        state_d   = state_q;
        elapsed_d = elapsed_q;
        mode_d    = mode_q;
        min_d     = min_q;
        max_d     = max_q;
        pass_d    = 1'b0;
        err_d     = 1'b0;
        code_d    = ErrNone;
        verdict   = '0;
        if (disable_i) begin
            state_d = StIdle;
        end else if (state_q == StIdle) begin
            if (rise_first && mode_in != ModeOff) begin
                mode_d  = mode_in;
                min_d   = dly_min_i;
                max_d   = dly_max_i;
                // A response on the trigger edge itself is judged at elapsed 0.
                verdict = judge(mode_in, dly_min_i, dly_max_i, '0, rise_second);
                if (verdict.done) begin
                    pass_d = ~verdict.fail;
                    err_d  = verdict.fail;
                    code_d = verdict.code;
                end else begin
                    state_d   = StWait;
                    elapsed_d = ElapsedOne;
                end
            end
        end else begin
            verdict = judge(mode_q, min_q, max_q, elapsed_q, rise_second);
            if (rise_first) begin
                // Retrigger: whatever the old window decided, OVERLAP owns the single pulse.
                err_d     = 1'b1;
                code_d    = ErrOverlap;
                mode_d    = mode_in;
                min_d     = dly_min_i;
                max_d     = dly_max_i;
                elapsed_d = ElapsedOne;
                state_d   = (mode_in == ModeOff) ? StIdle : StWait;
            end else if (verdict.done) begin
                pass_d  = ~verdict.fail;
                err_d   = verdict.fail;
                code_d  = verdict.code;
                state_d = StIdle;
            end else if (elapsed_q != ElapsedMax) begin
                elapsed_d = elapsed_q + ElapsedOne;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q   <= 1'b0;
            second_q  <= 1'b0;
            state_q   <= StIdle;
            elapsed_q <= '0;
            mode_q    <= ModeExact;
            min_q     <= '0;
            max_q     <= '0;
        end else begin
            first_q   <= first_i;
            second_q  <= second_i;
            state_q   <= state_d;
            elapsed_q <= elapsed_d;
            mode_q    <= mode_d;
            min_q     <= min_d;
            max_q     <= max_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ErrNone;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pass_q <= pass_d;
            err_q  <= err_d;
            if (err_d) begin
                code_q <= code_d;
            end else if (clr_i) begin
                code_q <= ErrNone;
            end
            // Clear beats a coincident error for the accumulated status.
            if (clr_i) begin
                sticky_q <= 1'b0;
                cnt_q    <= '0;
            end else if (err_d) begin
                sticky_q <= 1'b1;
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign pass_o       = pass_q;
    assign err_o        = err_q;
    assign err_code_o   = code_q;
    assign err_sticky_o = sticky_q;
    assign err_cnt_o    = cnt_q;

endmodule

// File: rtl/pulse_timing_checker.sv
// Multi-channel trigger->response timing checker; slices the flat config/status buses per channel.
module pulse_timing_checker
    import pulse_timing_pkg::*;
#(
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned DLY_W    = 8,
    parameter int unsigned ERRCNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          first_i,
    input  logic [NUM_CH-1:0]          second_i,
    input  logic [MODE_W*NUM_CH-1:0]   mode_i,
    input  logic [DLY_W*NUM_CH-1:0]    dly_min_i,
    input  logic [DLY_W*NUM_CH-1:0]    dly_max_i,
    input  logic [NUM_CH-1:0]          disable_i,
    input  logic                       clr_i,
    output logic [NUM_CH-1:0]          pass_o,
    output logic [NUM_CH-1:0]          err_o,
    output logic [CODE_W*NUM_CH-1:0]   err_code_o,
    output logic [NUM_CH-1:0]          err_sticky_o,
    output logic [ERRCNT_W*NUM_CH-1:0] err_cnt_o
);

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
        pulse_timing_channel #(
            .DLY_W    (DLY_W),
            .ERRCNT_W (ERRCNT_W)
        ) u_channel (
            .clk          (clk),
            .rst          (rst),
            .first_i      (first_i[g]),
            .second_i     (second_i[g]),
            .mode_i       (mode_i[MODE_W*g +: MODE_W]),
            .dly_min_i    (dly_min_i[DLY_W*g +: DLY_W]),
            .dly_max_i    (dly_max_i[DLY_W*g +: DLY_W]),
            .disable_i    (disable_i[g]),
            .clr_i        (clr_i),
            .pass_o       (pass_o[g]),
            .err_o        (err_o[g]),
            .err_code_o   (err_code_o[CODE_W*g +: CODE_W]),
            .err_sticky_o (err_sticky_o[g]),
            .err_cnt_o    (err_cnt_o[ERRCNT_W*g +: ERRCNT_W])
        );
    end

endmodule

// File: tb/tb_pulse_timing_checker.sv
// Bench for pulse_timing_checker: directed vector table, corner sequences and a scoreboarded model.
module tb_pulse_timing_checker;

    localparam int NCH = 8;
    localparam int DW  = 8;
    localparam int CW  = 10;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct packed {
        logic [NCH-1:0]    pass;
        logic [NCH-1:0]    err;
        logic [2*NCH-1:0]  code;
        logic [NCH-1:0]    sticky;
        logic [CW*NCH-1:0] cnt;
    } exp_t;

    typedef struct {
        int mode;
        int mn;
        int mx;
        int sec;
        int off;
        int p;
        int e;
        int code;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NCH-1:0]    first = '0;
    logic [NCH-1:0]    second = '0;
    logic [2*NCH-1:0]  mode = '1;
    logic [DW*NCH-1:0] dmin = '0;
    logic [DW*NCH-1:0] dmax = '0;
    logic [NCH-1:0]    dis = '0;
    logic              clr = 1'b0;
    logic [NCH-1:0]    pass_w, err_w, sticky_w;
    logic [2*NCH-1:0]  code_w;
    logic [CW*NCH-1:0] cnt_w;

    int n_chk = 0;
    int n_fail = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pulse_timing_checker #(
        .NUM_CH   (NCH),
        .DLY_W    (DW),
        .ERRCNT_W (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .first_i      (first),
        .second_i     (second),
        .mode_i       (mode),
        .dly_min_i    (dmin),
        .dly_max_i    (dmax),
        .disable_i    (dis),
        .clr_i        (clr),
        .pass_o       (pass_w),
        .err_o        (err_w),
        .err_code_o   (code_w),
        .err_sticky_o (sticky_w),
        .err_cnt_o    (cnt_w)
    );

    task automatic chk(input string nm, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {pass, err, code} of one channel as a small integer
    function automatic int obs(input int c);
        return int'(pass_w[c]) * 8 + int'(err_w[c]) * 4 + int'(code_w[2*c +: 2]);
    endfunction

    // Reference model: each window is tracked by its start cycle and a fixed deadline.
    int   cyc;
    int   m_t0[NCH], m_lo[NCH], m_hi[NCH], m_dl[NCH], m_md[NCH];
    bit   m_busy[NCH], m_fp[NCH], m_sp[NCH];
    exp_t m_out;

    task automatic arm(input int c);
        m_md[c]   = int'(mode[2*c +: 2]);
        m_lo[c]   = int'(dmin[DW*c +: DW]);
        m_hi[c]   = (m_md[c] == 0) ? m_lo[c] : int'(dmax[DW*c +: DW]);
        m_dl[c]   = m_hi[c] + 1;
        m_t0[c]   = cyc;
        m_busy[c] = (m_md[c] != 3);
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int c = 0; c < NCH; c++) begin
                    m_busy[c] = 0;
                    m_fp[c]   = 0;
                    m_sp[c]   = 0;
                end
                cyc   = 0;
                m_out = '0;
                exp_q.delete();
                exp_q.push_back(m_out);
            end else begin
                cyc++;
                for (int c = 0; c < NCH; c++) begin
                    bit rf, rs, hit, ok;
                    int el, cd, cv;
                    rf = first[c] && !m_fp[c];
                    rs = second[c] && !m_sp[c];
                    m_fp[c] = first[c];
                    m_sp[c] = second[c];
                    hit = 0;
                    ok  = 0;
                    cd  = 0;
                    if (dis[c]) begin
                        m_busy[c] = 0;
                    end else if (m_busy[c] && rf) begin
                        hit = 1;
                        cd  = 3;
                        arm(c);
                    end else begin
                        if (!m_busy[c] && rf) arm(c);
                        if (m_busy[c]) begin
                            el = cyc - m_t0[c];
                            if (rs) begin
                                m_busy[c] = 0;
                                if (m_md[c] == 2) begin
                                    hit = (el >= m_lo[c] && el <= m_hi[c]);
                                    ok  = !hit;
                                    cd  = 1;
                                end else if (el < m_lo[c]) begin
                                    hit = 1;
                                    cd  = 1;
                                end else if (el <= m_hi[c]) begin
                                    ok = 1;
                                end else begin
                                    hit = 1;
                                    cd  = 2;
                                end
                            end else if (el == m_dl[c]) begin
                                m_busy[c] = 0;
                                ok  = (m_md[c] == 2);
                                hit = !ok;
                                cd  = 2;
                            end
                        end
                    end
                    m_out.pass[c] = ok;
                    m_out.err[c]  = hit;
                    if (hit) m_out.code[2*c +: 2] = 2'(cd);
                    else if (clr) m_out.code[2*c +: 2] = 2'd0;
                    cv = int'(m_out.cnt[CW*c +: CW]);
                    if (clr) begin
                        m_out.sticky[c] = 0;
                        cv = 0;
                    end else if (hit) begin
                        m_out.sticky[c] = 1;
                        if (cv < CNT_MAX) cv++;
                    end
                    m_out.cnt[CW*c +: CW] = CW'(cv);
                end
                exp_q.push_back(m_out);
            end
        end
    end

    initial begin
        forever begin
            exp_t e, a;
            @(negedge clk);
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty at t=%0t", $time);
            end else begin
                e        = exp_q.pop_front();
                a.pass   = pass_w;
                a.err    = err_w;
                a.code   = code_w;
                a.sticky = sticky_w;
                a.cnt    = cnt_w;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t: got %h, expected %h", $time, a, e);
                end
            end
        end
    end

    vec_t vt[16];

    initial begin
        int res, pulses;
        bit seen;

        vt[0]  = '{0, 3, 0,  3, 4, 1, 0, 0};
        vt[1]  = '{0, 3, 0,  2, 3, 0, 1, 1};
        vt[2]  = '{0, 3, 0, -1, 5, 0, 1, 2};
        vt[3]  = '{1, 2, 5,  2, 3, 1, 0, 0};
        vt[4]  = '{1, 2, 5,  5, 6, 1, 0, 0};
        vt[5]  = '{1, 2, 5,  1, 2, 0, 1, 1};
        vt[6]  = '{1, 2, 5, -1, 7, 0, 1, 2};
        vt[7]  = '{2, 2, 5,  4, 5, 0, 1, 1};
        vt[8]  = '{2, 2, 5,  7, 7, 1, 0, 0};
        vt[9]  = '{0, 0, 0,  0, 1, 1, 0, 0};
        vt[10] = '{1, 5, 2,  4, 4, 0, 1, 2};
        vt[11] = '{2, 5, 2, -1, 4, 1, 0, 0};
        vt[12] = '{1, 0, 0,  0, 1, 1, 0, 0};
        vt[13] = '{0, 2, 0,  3, 4, 0, 1, 2};
        vt[14] = '{2, 2, 5,  0, 1, 1, 0, 0};
        vt[15] = '{2, 0, 3,  0, 1, 0, 1, 1};

        #1 rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("reset_state", int'(|{pass_w, err_w, code_w, sticky_w, cnt_w}), 0);

        // Directed vectors on channel 0; result = offset*16 + pass*8 + err*4 + code
        for (int i = 0; i < 16; i++) begin
            mode[1:0] = 2'(vt[i].mode);
            dmin[7:0] = 8'(vt[i].mn);
            dmax[7:0] = 8'(vt[i].mx);
            first[0]  = 1'b1;
            seen      = 0;
            res       = 0;
            for (int j = 0; j <= 10; j++) begin
                if (j == vt[i].sec) second[0] = 1'b1;
                step();
                if (!seen && (pass_w[0] || err_w[0])) begin
                    seen = 1;
                    res  = (j + 1) * 16 + obs(0) - (err_w[0] ? 0 : int'(code_w[1:0]));
                end
            end
            first[0]  = 1'b0;
            second[0] = 1'b0;
            step();
            step();
            chk($sformatf("vector%0d", i), res,
                vt[i].off * 16 + vt[i].p * 8 + vt[i].e * 4 + vt[i].code);
        end

        // Retrigger at T0+2 (EXACT 4), response at T0+5
        mode[1:0] = 2'd0;
        dmin[7:0] = 8'd4;
        first[0]  = 1'b1;
        step();
        first[0] = 1'b0;
        step();
        first[0] = 1'b1;
        step();
        chk("overlap_pulse", obs(0), 7);
        step();
        step();
        second[0] = 1'b1;
        step();
        chk("overlap_then_early", obs(0), 5);
        first[0]  = 1'b0;
        second[0] = 1'b0;
        step();
        step();

        // disable_i mid-window suppresses the decision
        dmin[7:0] = 8'd3;
        pulses    = 0;
        first[0]  = 1'b1;
        step();
        dis[0] = 1'b1;
        step();
        pulses += int'(pass_w[0] | err_w[0]);
        step();
        pulses += int'(pass_w[0] | err_w[0]);
        second[0] = 1'b1;
        step();
        pulses += int'(pass_w[0] | err_w[0]);
        dis[0] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            pulses += int'(pass_w[0] | err_w[0]);
        end
        chk("disable_suppresses", pulses, 0);
        first[0]  = 1'b0;
        second[0] = 1'b0;
        step();

        // Reset in the middle of a window
        pulses   = 0;
        first[0] = 1'b1;
        step();
        step();
        rst      = 1'b1;
        first[0] = 1'b0;
        step();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            pulses += int'(pass_w[0] | err_w[0]);
        end
        chk("reset_abort", pulses, 0);
        chk("reset_clears_status", int'(|{code_w, sticky_w, cnt_w}), 0);

        // Counter saturation on channel 1: EXACT 0 without response -> LATE per trigger
        mode[3:2] = 2'd0;
        dmin[15:8] = 8'd0;
        for (int k = 0; k < CNT_MAX + 3; k++) begin
            first[1] = 1'b1;
            step();
            first[1] = 1'b0;
            step();
        end
        chk("cnt_saturated", int'(cnt_w[CW +: CW]), CNT_MAX);
        chk("sticky_set", int'(sticky_w[1]), 1);
        chk("code_late_held", int'(code_w[3:2]), 2);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_cnt", int'(cnt_w[CW +: CW]), 0);
        chk("clr_sticky", int'(sticky_w[1]), 0);
        chk("clr_code", int'(code_w[3:2]), 0);

        // Clear coinciding with an error: pulse and code survive, status stays clear
        first[1] = 1'b1;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_coinc_pulse", obs(1), 6);
        chk("clr_coinc_cnt", int'(cnt_w[CW +: CW]), 0);
        chk("clr_coinc_sticky", int'(sticky_w[1]), 0);
        first[1] = 1'b0;
        step();

        // Random traffic on all channels against the model
        for (int n = 0; n < 20000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                first[c]  = ($urandom_range(0, 2 + c) == 0);
                second[c] = ($urandom_range(0, 2) == 0);
                dis[c]    = ($urandom_range(0, 63) == 0);
                if ($urandom_range(0, 15) == 0) begin
                    mode[2*c +: 2]  = 2'($urandom_range(0, 3));
                    dmin[DW*c +: DW] = 8'($urandom_range(0, 6));
                    dmax[DW*c +: DW] = 8'($urandom_range(0, 6));
                end
            end
            clr = ($urandom_range(0, 199) == 0);
            if (n % 5000 == 4999) rst = 1'b1;
            step();
            rst = 1'b0;
        end
        first  = '0;
        second = '0;
        dis    = '0;
        clr    = 1'b0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
